// File: rtl/fft_frame_sched.sv
// Frame scheduler around fft_control: streams a frame into the 4 data banks, runs the core, streams the result out.
// Latency: one IDLE cycle after reset, N load beats, a 1-cycle START pulse, then the core time, then N unload beats behind a 1-cycle RAM read.
// Backpressure: oIN_READY is high only in LOAD, and the unload read address is held while iOUT_READY stalls a valid beat.
// Optional feature macro FFT_BITREV_UNLOAD_EN: unload in bit-reversed index order (natural order from DIT storage).
module fft_frame_sched #(
  parameter int LOG2N   = 11,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 8192
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iIN_VALID,
  output logic              oIN_READY,
  output logic              oLD_WE,
  output logic [1:0]        oLD_BANK,
  output logic [ADDR_W-1:0] oLD_ADDR,
  output logic              oFFT_START,
  input  logic              iFFT_RDY,
  output logic              oRD_EN,
  output logic [1:0]        oRD_BANK,
  output logic [ADDR_W-1:0] oRD_ADDR,
  output logic              oOUT_VALID,
  input  logic              iOUT_READY,
  output logic              oOUT_LAST,
  output logic [1:0]        oMEM_OWNER,
  output logic              oBUSY,
  output logic              oERR
);

  localparam int N     = 1 << LOG2N;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [TMR_W-1:0] TMO_VAL  = TMR_W'(TIMEOUT);

  localparam logic [1:0] OWN_LOAD = 2'd0;
  localparam logic [1:0] OWN_FFT  = 2'd1;
  localparam logic [1:0] OWN_UNLD = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_UNLOAD
  } state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] n_q, n_d;             // load sample counter
  logic [LOG2N-1:0] k_q, k_d;             // next unload index to issue
  logic [LOG2N-1:0] out_idx_q, out_idx_d; // index of the beat currently on the output
  logic             rd_pend_q, rd_pend_d; // indices remain to be issued
  logic             out_vld_q, out_vld_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;         // cycles since START
  logic             in_ready_q, in_ready_d;
  logic             fft_start_q, fft_start_d;
  logic [1:0]       owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             in_unload;
  logic             stall;
  logic             rd_en;
  logic [LOG2N-1:0] rd_idx;
  logic [LOG2N-1:0] rd_m;

`ifdef FFT_BITREV_UNLOAD_EN
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction
`endif

  // Unload read port: while a beat is stalled, re-read that beat's own address so the
  // RAM output stays stable; otherwise issue the next index.
  always_comb begin
    in_unload = (state_q == S_UNLOAD);
    stall     = out_vld_q & ~iOUT_READY;
    rd_en     = in_unload & (stall | rd_pend_q);
    rd_idx    = stall ? out_idx_q : k_q;
`ifdef FFT_BITREV_UNLOAD_EN
    rd_m      = bitrev(rd_idx);
`else
    rd_m      = rd_idx;
`endif
  end

  // Next-state and next-output logic for the frame FSM and its counters.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    out_idx_d   = out_idx_q;
    rd_pend_d   = rd_pend_q;
    out_vld_d   = out_vld_q;
    tmr_d       = tmr_q;
    in_ready_d  = in_ready_q;
    fft_start_d = 1'b0;
    owner_d     = owner_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        // A latched timeout parks the scheduler here until reset.
        if (!err_q) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
          owner_d    = OWN_LOAD;
          n_d        = '0;
        end else begin
          owner_d    = OWN_NONE;
        end
      end

      S_LOAD: begin
        if (iIN_VALID && in_ready_q) begin
          if (n_q == LAST_IDX) begin
            state_d     = S_START;
            n_d         = '0;
            in_ready_d  = 1'b0;
            owner_d     = OWN_FFT;
            fft_start_d = 1'b1;
            tmr_d       = '0;
          end else begin
            n_d = n_q + LOG2N'(1);
          end
        end
      end

      S_START: begin
        state_d = S_WAIT_LO;
        tmr_d   = tmr_q + TMR_W'(1);
      end

      S_WAIT_LO, S_WAIT_HI: begin
        tmr_d = tmr_q + TMR_W'(1);
        // Progress of the core wins over a timeout landing on the same cycle.
        if (state_q == S_WAIT_LO && !iFFT_RDY) begin
          state_d = S_WAIT_HI;
        end else if (state_q == S_WAIT_HI && iFFT_RDY) begin
          state_d   = S_UNLOAD;
          owner_d   = OWN_UNLD;
          k_d       = '0;
          out_idx_d = '0;
          rd_pend_d = 1'b1;
          out_vld_d = 1'b0;
          tmr_d     = '0;
        end else if (tmr_q == TMO_VAL) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
          err_d   = 1'b1;
          tmr_d   = '0;
        end
      end

      S_UNLOAD: begin
        out_vld_d = rd_en;
        if (!stall && rd_pend_q) begin
          out_idx_d = k_q;
          if (k_q == LAST_IDX) begin
            rd_pend_d = 1'b0;
          end else begin
            k_d = k_q + LOG2N'(1);
          end
        end
        // Last beat handed off: go straight back to loading the next frame.
        if (out_vld_q && iOUT_READY && (out_idx_q == LAST_IDX)) begin
          state_d    = S_LOAD;
          owner_d    = OWN_LOAD;
          in_ready_d = 1'b1;
          n_d        = '0;
          k_d        = '0;
          out_idx_d  = '0;
          out_vld_d  = 1'b0;
          rd_pend_d  = 1'b0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        owner_d    = OWN_NONE;
        in_ready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counter and registered-output flops; reset aborts any frame in progress.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      out_idx_q   <= '0;
      rd_pend_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      tmr_q       <= '0;
      in_ready_q  <= 1'b0;
      fft_start_q <= 1'b0;
      owner_q     <= OWN_NONE;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      out_idx_q   <= out_idx_d;
      rd_pend_q   <= rd_pend_d;
      out_vld_q   <= out_vld_d;
      tmr_q       <= tmr_d;
      in_ready_q  <= in_ready_d;
      fft_start_q <= fft_start_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign oIN_READY  = in_ready_q;
  assign oLD_WE     = iIN_VALID & in_ready_q;
  assign oLD_BANK   = n_q[1:0];
  assign oLD_ADDR   = n_q[LOG2N-1:2];
  assign oFFT_START = fft_start_q;
  assign oRD_EN     = rd_en;
  assign oRD_BANK   = rd_m[1:0];
  assign oRD_ADDR   = rd_m[LOG2N-1:2];
  assign oOUT_VALID = out_vld_q;
  assign oOUT_LAST  = out_vld_q & (out_idx_q == LAST_IDX);
  assign oMEM_OWNER = owner_q;
  assign oBUSY      = busy_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: load/start/unload sequencing, stall hold, reset abort, timeout.
// A tiny RAM model echoes the read address one cycle later as the read data.
module tb_fft_frame_sched;
  localparam int LOG2N   = 11;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 8192;
  localparam int N       = 1 << LOG2N;

  logic              iCLK = 1'b0;
  logic              iRESET;
  logic              iIN_VALID;
  logic              oIN_READY;
  logic              oLD_WE;
  logic [1:0]        oLD_BANK;
  logic [ADDR_W-1:0] oLD_ADDR;
  logic              oFFT_START;
  logic              iFFT_RDY;
  logic              oRD_EN;
  logic [1:0]        oRD_BANK;
  logic [ADDR_W-1:0] oRD_ADDR;
  logic              oOUT_VALID;
  logic              iOUT_READY;
  logic              oOUT_LAST;
  logic [1:0]        oMEM_OWNER;
  logic              oBUSY;
  logic              oERR;

  int n_tests = 0;
  int n_fail  = 0;
  int beats;

  logic [LOG2N-1:0] ram_q;

  fft_frame_sched #(.LOG2N(LOG2N), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iIN_VALID(iIN_VALID), .oIN_READY(oIN_READY),
    .oLD_WE(oLD_WE), .oLD_BANK(oLD_BANK), .oLD_ADDR(oLD_ADDR), .oFFT_START(oFFT_START),
    .iFFT_RDY(iFFT_RDY), .oRD_EN(oRD_EN), .oRD_BANK(oRD_BANK), .oRD_ADDR(oRD_ADDR),
    .oOUT_VALID(oOUT_VALID), .iOUT_READY(iOUT_READY), .oOUT_LAST(oOUT_LAST),
    .oMEM_OWNER(oMEM_OWNER), .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  // RAM model: the data word returned is the index {addr,bank} that was read.
  always @(posedge iCLK) begin
    if (oRD_EN) ram_q <= {oRD_ADDR, oRD_BANK};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [31:0] exp_idx(input int k);
    logic [LOG2N-1:0] kv;
    logic [LOG2N-1:0] r;
    kv = LOG2N'(k);
`ifdef FFT_BITREV_UNLOAD_EN
    for (int i = 0; i < LOG2N; i++) r[i] = kv[LOG2N-1-i];
`else
    r = kv;
`endif
    return 32'(r);
  endfunction

  // Stream one frame in; on return the DUT sits in the cycle after sample N-1 was accepted.
  task automatic load_frame(input bit gappy);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    while (n < N && cyc < 8000) begin
      iIN_VALID = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("ld_ready", oIN_READY, 1);
      chk("ld_start_low", oFFT_START, 0);
      if (iIN_VALID) begin
        chk("ld_we", oLD_WE, 1);
        chk("ld_bank", oLD_BANK, n % 4);
        chk("ld_addr", oLD_ADDR, n / 4);
        n++;
      end
      cyc++;
      tick();
    end
    chk("ld_count", n, N);
    iIN_VALID = 1'b1;
  endtask

  // Check the START pulse, then play fft_control: drop RDY, hold, raise RDY.
  task automatic fft_handshake();
    chk("start_pulse", oFFT_START, 1);
    chk("start_owner", oMEM_OWNER, 1);
    chk("start_in_ready", oIN_READY, 0);
    chk("start_ld_we", oLD_WE, 0);
    iFFT_RDY = 1'b0;
    tick();
    chk("start_single", oFFT_START, 0);
    repeat (4) tick();
    chk("wait_owner", oMEM_OWNER, 1);
    chk("wait_rd_en", oRD_EN, 0);
    chk("wait_busy", oBUSY, 1);
    iFFT_RDY = 1'b1;
    tick();
    chk("unload_owner", oMEM_OWNER, 2);
    chk("unload_rd_en", oRD_EN, 1);
    chk("unload_first_valid", oOUT_VALID, 0);
  endtask

  task automatic unload_frame(input bit rnd, input int stop_at, output int got);
    int e;
    int cyc;
    bit prev_stall;
    logic [LOG2N-1:0] prev_a;
    e = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_a = '0;
    while (e < stop_at && cyc < 12000) begin
      iOUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("ul_ld_we", oLD_WE, 0);
      if (oOUT_VALID) begin
        chk("ul_data", 32'(ram_q), exp_idx(e));
        chk("ul_last", oOUT_LAST, (e == N - 1) ? 1 : 0);
        if (prev_stall && !iOUT_READY) chk("ul_addr_hold", {oRD_ADDR, oRD_BANK}, 32'(prev_a));
        if (iOUT_READY) e++;
      end else begin
        chk("ul_last_no_valid", oOUT_LAST, 0);
      end
      prev_stall = oOUT_VALID && !iOUT_READY;
      prev_a = {oRD_ADDR, oRD_BANK};
      cyc++;
      tick();
    end
    chk("ul_beats", e, stop_at);
    got = e;
  endtask

  initial begin
    iRESET     = 1'b0;
    iIN_VALID  = 1'b1;
    iFFT_RDY   = 1'b1;
    iOUT_READY = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_in_ready", oIN_READY, 0);
    chk("rst_ld_we", oLD_WE, 0);
    chk("rst_start", oFFT_START, 0);
    chk("rst_rd_en", oRD_EN, 0);
    chk("rst_out_valid", oOUT_VALID, 0);
    chk("rst_owner", oMEM_OWNER, 3);
    chk("rst_busy", oBUSY, 0);
    chk("rst_err", oERR, 0);

    // One IDLE cycle, then LOAD.
    iRESET = 1'b1;
    #1;
    chk("idle_busy", oBUSY, 0);
    chk("idle_owner", oMEM_OWNER, 3);
    tick();
    chk("load_owner", oMEM_OWNER, 0);
    chk("load_busy", oBUSY, 1);

    // Frame 1: back-to-back load, full-rate unload.
    load_frame(1'b0);
    fft_handshake();
    unload_frame(1'b0, N, beats);
    chk("next_in_ready", oIN_READY, 1);
    chk("next_owner", oMEM_OWNER, 0);
    chk("next_out_valid", oOUT_VALID, 0);
    chk("next_ld_bank", oLD_BANK, 0);
    chk("next_ld_addr", oLD_ADDR, 0);

    // Frame 2: gappy load, random downstream stalls.
    load_frame(1'b1);
    fft_handshake();
    unload_frame(1'b1, N, beats);

    // Frame 3: reset in the middle of the unload.
    load_frame(1'b0);
    fft_handshake();
    unload_frame(1'b0, 700, beats);
    chk("pre_abort_owner", oMEM_OWNER, 2);
    iRESET = 1'b0;
    #1;
    chk("abort_rd_en", oRD_EN, 0);
    chk("abort_out_valid", oOUT_VALID, 0);
    chk("abort_last", oOUT_LAST, 0);
    chk("abort_rd_addr", oRD_ADDR, 0);
    chk("abort_in_ready", oIN_READY, 0);
    chk("abort_ld_we", oLD_WE, 0);
    chk("abort_owner", oMEM_OWNER, 3);
    chk("abort_busy", oBUSY, 0);
    tick();
    iRESET = 1'b1;
    tick();
    chk("reload_owner", oMEM_OWNER, 0);

    // Frame 4: core never acknowledges, timeout.
    load_frame(1'b0);
    chk("tmo_start", oFFT_START, 1);
    for (int c = 1; c <= TIMEOUT; c++) tick();
    chk("tmo_err_early", oERR, 0);
    chk("tmo_busy_early", oBUSY, 1);
    tick();
    chk("tmo_err", oERR, 1);
    chk("tmo_busy", oBUSY, 0);
    chk("tmo_owner", oMEM_OWNER, 3);
    repeat (3) tick();
    chk("tmo_hold_idle", oBUSY, 0);
    chk("tmo_hold_ready", oIN_READY, 0);
    chk("tmo_sticky", oERR, 1);
    iRESET = 1'b0;
    #1;
    chk("tmo_cleared", oERR, 0);
    iRESET = 1'b1;
    tick();
    chk("tmo_recover_ready", oIN_READY, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
